// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: stall bus constants, divider
// state encodings and the HI/LO result width.
package div_unit_pkg;

  localparam int   StallBus     = 6;
  localparam logic Stop         = 1'b1;
  localparam int   DivResultBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; stalls EX while busy and
// returns {remainder, quotient} with a one-cycle ready pulse.
//
// state     | meaning
// DivFree   | idle, waiting for div_en
// DivByZero | divisor was zero, result forced to 0
// DivOn     | one quotient bit per cycle, 32 cycles
// DivEnd    | result valid, ready high for one cycle
module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    div_en,
  input  logic                    signed_div,
  input  logic [31:0]             opdata1,
  input  logic [31:0]             opdata2,
  input  logic                    annul,
  output logic                    stallreq_for_ex,
  output logic [DivResultBus-1:0] result,
  output logic                    ready
);

  div_state_e  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_work;
  logic [31:0] r_divisor;
  logic        r_q_neg;
  logic        r_r_neg;

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_upper;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_next;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign stallreq_for_ex = (div_en && (r_state != DivEnd) && !annul) ? Stop : ~Stop;

  assign w_abs1 = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
  assign w_abs2 = (signed_div && opdata2[31]) ? -opdata2 : opdata2;

  // Partial remainder is always below the divisor, so the 32-bit difference
  // of the shifted value cannot lose a carry.
  assign w_upper = r_work[63:31];
  assign w_ge    = w_upper >= {1'b0, r_divisor};
  assign w_diff  = r_work[62:31] - r_divisor;
  assign w_next  = w_ge ? {w_diff, r_work[30:0], 1'b1} : {r_work[62:0], 1'b0};

  assign w_quo = r_q_neg ? -w_next[31:0]  : w_next[31:0];
  assign w_rem = r_r_neg ? -w_next[63:32] : w_next[63:32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= DivFree;
      r_cnt     <= 6'd0;
      r_work    <= 64'd0;
      r_divisor <= 32'd0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else if (annul) begin
      r_state <= DivFree;
      ready   <= 1'b0;
    end else begin
      case (r_state)
        DivFree: begin
          ready <= 1'b0;
          if (div_en) begin
            r_work    <= {32'd0, w_abs1};
            r_divisor <= w_abs2;
            r_q_neg   <= signed_div & (opdata1[31] ^ opdata2[31]);
            r_r_neg   <= signed_div & opdata1[31];
            r_cnt     <= 6'd0;
            r_state   <= (opdata2 == 32'd0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result  <= '0;
          ready   <= 1'b1;
          r_state <= DivEnd;
        end
        DivOn: begin
          r_work <= w_next;
          r_cnt  <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            result  <= {w_rem, w_quo};
            ready   <= 1'b1;
            r_state <= DivEnd;
          end
        end
        DivEnd: begin
          ready   <= 1'b0;
          r_state <= DivFree;
        end
        default: r_state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at start and
// compared when ready pulses, together with latency and stall length.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        div_en;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        stallreq_for_ex;
  logic [63:0] result;
  logic        ready;

  logic [63:0] exp_q[$];
  logic [63:0] last_exp;
  int          n_checks;
  int          n_fail;

  div_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .div_en         (div_en),
    .signed_div     (signed_div),
    .opdata1        (opdata1),
    .opdata2        (opdata2),
    .annul          (annul),
    .stallreq_for_ex(stallreq_for_ex),
    .result         (result),
    .ready          (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge: drives a new operation into the current cycle.
  task automatic start_div(input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
    div_en     = 1'b1;
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    if (push) exp_q.push_back(model(s, a, b));
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input int exp_stall);
    int k;
    int stall_cnt;
    bit done;
    logic [63:0] e;
    k = 0;
    stall_cnt = 0;
    done = 1'b0;
    #1;
    while (!done && k < 80) begin
      if (stallreq_for_ex) stall_cnt++;
      @(posedge clk);
      @(negedge clk);
      k++;
      if (ready) done = 1'b1;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
    chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    if (done) begin
      chk({tag, "_stall_in_end"}, 64'(stallreq_for_ex), 64'd0);
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected_ready"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        chk({tag, "_result"}, result, e);
      end
    end
  endtask

  task automatic close_div(input string tag);
    div_en = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_pulse"}, 64'(ready), 64'd0);
    chk({tag, "_result_hold"}, result, last_exp);
  endtask

  initial begin
    bit saw_ready;
    logic [31:0] ra, rb;
    bit rs;
    n_checks   = 0;
    n_fail     = 0;
    last_exp   = 64'd0;
    resetn     = 1'b0;
    div_en     = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    annul      = 1'b0;

    #3;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_stall_idle", 64'(stallreq_for_ex), 64'd0);
    div_en = 1'b1;
    #1;
    chk("rst_stall_follows_en", 64'(stallreq_for_ex), 64'd1);
    div_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    start_div(1'b0, 32'd100, 32'd7, 1'b1);
    wait_result("u100_7", 33, 33);
    chk("u100_7_const", result, {32'd2, 32'd14});
    close_div("u100_7");

    start_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_result("s_m7_2", 33, 33);
    chk("s_m7_2_const", result, {32'hFFFFFFFF, 32'hFFFFFFFD});
    close_div("s_m7_2");

    start_div(1'b0, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_result("u_m7_2", 33, 33);
    chk("u_m7_2_const", result, {32'd1, 32'h7FFFFFFC});
    close_div("u_m7_2");

    start_div(1'b1, 32'd12345, 32'd0, 1'b1);
    wait_result("dzero", 2, 2);
    chk("dzero_const", result, 64'd0);
    close_div("dzero");

    start_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_result("ovf", 33, 33);
    chk("ovf_const", result, {32'h0, 32'h80000000});
    close_div("ovf");

    // Flush in the middle of ON
    start_div(1'b0, 32'd999, 32'd5, 1'b0);
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul_stall_drop", 64'(stallreq_for_ex), 64'd0);
    @(negedge clk);
    annul  = 1'b0;
    div_en = 1'b0;
    chk("annul_state_idle", 64'(dut.r_state), 64'(DivFree));
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready) saw_ready = 1'b1;
      @(negedge clk);
    end
    chk("annul_no_ready", 64'(saw_ready), 64'd0);
    chk("annul_result_kept", result, last_exp);

    start_div(1'b0, 32'd100, 32'd7, 1'b1);
    wait_result("after_annul", 33, 33);
    close_div("after_annul");

    // Back-to-back: second operation presented during END
    start_div(1'b0, 32'd1000, 32'd3, 1'b1);
    wait_result("b2b_first", 33, 33);
    start_div(1'b1, 32'hFFFFFC18, 32'd7, 1'b1);
    wait_result("b2b_second", 34, 33);
    close_div("b2b_second");

    start_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
    wait_result("u_max_1", 33, 33);
    close_div("u_max_1");

    start_div(1'b1, 32'd3, 32'hFFFFFFF6, 1'b1);
    wait_result("s_3_m10", 33, 33);
    close_div("s_3_m10");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      rs = 1'($urandom_range(0, 1));
      start_div(rs, ra, rb, 1'b1);
      wait_result("rand", (rb == 32'd0) ? 2 : 33, (rb == 32'd0) ? 2 : 33);
      close_div("rand");
    end

    // Asynchronous reset in the middle of ON
    start_div(1'b0, 32'd77, 32'd4, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_state", 64'(dut.r_state), 64'(DivFree));
    div_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    last_exp = 64'd0;

    start_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1);
    wait_result("after_rst", 33, 33);
    close_div("after_rst");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the EX stage, serving DIV/DIVU. It is the requesting side of the pipeline stall protocol: it raises `stallreq_for_ex` toward the stall controller for as long as a division is in flight. It returns `{remainder, quotient}` for the HI/LO write path. It uses one radix-2 restoring iteration per cycle and can be annulled by a pipeline flush.

## Interface
- No parameters. Widths are fixed: operands 32, result 64.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `div_en` in 1: EX holds a DIV/DIVU. Held stable by the stall while `stallreq_for_ex` is high.
- `signed_div` in 1: 1 means DIV, 0 means DIVU. Sampled at start.
- `opdata1` in 32: dividend, sampled at start.
- `opdata2` in 32: divisor, sampled at start.
- `annul` in 1: flush. Abort any operation and return to IDLE.
- `stallreq_for_ex` out 1: combinational, equal to `div_en && state != END && !annul`.
- `result` out 64: `[63:32]` is the remainder (HI), `[31:0]` is the quotient (LO). Valid only while `ready` is high.
- `ready` out 1: result valid. A 1-cycle pulse in END.

## Operation
- States: IDLE, DZERO, ON, END. Two-bit encoding.
- **IDLE**
  - If `div_en && !annul`: latch the operands and `signed_div`.
  - If `opdata2 == 0`, go to DZERO. Otherwise clear `cnt` and go to ON.
- **Signed mode**
  - Latch the absolute values of both operands.
  - Record `q_neg = op1[31] ^ op2[31]` and `r_neg = op1[31]`.
- **ON**
  - Each cycle, shift the 64-bit remainder/dividend register left by 1 and compare the upper 33 bits with the divisor.
  - If greater or equal: subtract, and shift in quotient bit 1. Otherwise shift in 0.
  - `cnt` is 6 bits and increments each cycle. When `cnt == 31` is processed, go to END.
- **END**
  - Apply the sign fix: negate the quotient if `q_neg`, negate the remainder if `r_neg`. Both are two's complement, mod 2^32.
  - Drive `result` and set `ready = 1`.
  - Go to IDLE unconditionally on the next edge. This allows back-to-back divides.
- **DZERO**: go to END with a raw result of 64'h0. No sign fix is applied, so `result = 0`.
- **annul**: when high in any state, the next state is IDLE. `ready` stays 0 and `result` is not updated. `annul` has priority over start.
- **Overflow case**: signed 0x80000000 / 0xFFFFFFFF needs no special case. The result is quotient 0x80000000, remainder 0, produced by the mod-2^32 wrap.
- **Reset values**: state IDLE, `cnt` 0, `result` 64'h0, `ready` 0. `stallreq_for_ex` equals `div_en`.
- **Reset mid-operation**: immediately returns to IDLE. The partial result is discarded.

## Timing
- Start is sampled at edge T, with IDLE and `div_en` high.
- ON occupies cycles T+1 through T+32. END (`ready` high) is cycle T+33.
- `stallreq_for_ex` is high in cycles T through T+32 and low in T+33. The EX/MEM register captures `result` at the end of T+33.
- Divide by zero: DZERO in T+1, END in T+2. Stall is high in T through T+1.
- The stall depends on `div_en` and `annul` combinationally. There is no registered-output delay.
- `ready` and `result` are registered. `result` holds its value after END until the next END.

## Structure
- Shared defines header additions:
  - `StallBus` (6) and `Stop` (1'b1), reused.
  - State encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
  - `DivResultBus` (64).
- Single module, no sub-modules. The absolute-value and negate logic are inline expressions.

## Test plan
- Unsigned 100 / 7 started at T: `stallreq_for_ex` is high for T..T+32, and `ready` pulses at T+33 with `result = {32'd2, 32'd14}`.
- Signed -7 / 2 (0xFFFFFFF9 / 2): `result = {32'hFFFFFFFF, 32'hFFFFFFFD}` at T+33. Unsigned with the same operands gives `{32'd1, 32'h7FFFFFFC}`.
- Divisor 0: `ready` at T+2, `result = 64'h0`, stall high for exactly 2 cycles.
- Signed 0x80000000 / 0xFFFFFFFF: `result = {32'h0, 32'h80000000}`.
- `annul` at T+10: state is IDLE at T+11, no `ready` pulse, stall drops in the `annul` cycle. A new divide started afterwards completes correctly.
- Two divides back-to-back, the second started the cycle after END: both results are correct, 34 cycles apart. Asserting `resetn` low mid-ON clears `ready`/`result` asynchronously.
